// File: rtl/alu_pipe_shared.sv
// Two-stage shared-subexpression ALU with valid/ready handshake on both sides.
// Stage 1 registers the shared sums; stage 2 selects the result, flags and accumulator.
module alu_pipe_shared #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] input_c,
    input  logic [WIDTH-1:0] input_d,
    input  logic [3:0]       opcode,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag
);

    localparam int W = WIDTH;

    logic [W:0]   s_ab_q, s_ab_d, s_cd_q, s_cd_d, s_ac_q, s_ac_d, s_bd_q, s_bd_d;
    logic [W-1:0] d_ab_q, d_ab_d, a_q, a_d, b_q, b_d;
    logic         brw_q, brw_d, sel_q, sel_d, s1_full_q, s1_full_d;
    logic [3:0]   op_q, op_d;

    logic [W-1:0] result_q, result_d, acc_q, acc_d;
    logic         zero_q, zero_d, carry_q, carry_d, out_valid_q, out_valid_d;

    logic         s2_load, in_xfer;
    logic [W+1:0] add4;
    logic [W:0]   acc_sum;
    logic [W-1:0] res, acc_nxt;
    logic         cy;

    // Stage 2 may load when it is empty or its result is leaving this cycle.
    assign s2_load = s1_full_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_full_q || s2_load;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        s_ab_d    = s_ab_q;
        s_cd_d    = s_cd_q;
        s_ac_d    = s_ac_q;
        s_bd_d    = s_bd_q;
        d_ab_d    = d_ab_q;
        brw_d     = brw_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        op_d      = op_q;
        s1_full_d = s1_full_q;
        if (in_xfer) begin
            s_ab_d    = {1'b0, input_a} + {1'b0, input_b};
            s_cd_d    = {1'b0, input_c} + {1'b0, input_d};
            s_ac_d    = {1'b0, input_a} + {1'b0, input_c};
            s_bd_d    = {1'b0, input_b} + {1'b0, input_d};
            d_ab_d    = input_a - input_b;
            brw_d     = input_a < input_b;
            a_d       = input_a;
            b_d       = input_b;
            sel_d     = sel;
            op_d      = opcode;
            s1_full_d = 1'b1;
        end else if (s2_load) begin
            s1_full_d = 1'b0;
        end
    end

    always_comb begin
        add4    = {1'b0, s_ab_q} + {1'b0, s_cd_q};
        acc_sum = {1'b0, acc_q} + {1'b0, a_q};
        res     = '0;
        cy      = 1'b0;
        acc_nxt = acc_q;
        case (op_q)
            4'b0000, 4'b0111: begin
                res = add4[W-1:0];
                cy  = |add4[W+1:W];
            end
            4'b0001: begin
                res = d_ab_q;
                cy  = brw_q;
            end
            4'b0010: res = a_q & b_q;
            4'b0011: res = a_q | b_q;
            4'b0100: res = a_q ^ b_q;
            4'b0101: res = ~a_q;
            4'b0110: begin
                res = sel_q ? s_ac_q[W-1:0] : s_bd_q[W-1:0];
                cy  = sel_q ? s_ac_q[W] : s_bd_q[W];
            end
            4'b1000: begin
                res     = acc_sum[W-1:0];
                cy      = acc_sum[W];
                acc_nxt = acc_sum[W-1:0];
            end
            4'b1001: acc_nxt = '0;
            default: ;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        if (s2_load) begin
            result_d    = res;
            zero_d      = (res == '0);
            carry_d     = cy;
            acc_d       = acc_nxt;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_ab_q      <= '0;
            s_cd_q      <= '0;
            s_ac_q      <= '0;
            s_bd_q      <= '0;
            d_ab_q      <= '0;
            brw_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= 1'b0;
            op_q        <= '0;
            s1_full_q   <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s_ab_q      <= s_ab_d;
            s_cd_q      <= s_cd_d;
            s_ac_q      <= s_ac_d;
            s_bd_q      <= s_bd_d;
            d_ab_q      <= d_ab_d;
            brw_q       <= brw_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            op_q        <= op_d;
            s1_full_q   <= s1_full_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_pipe_shared.sv
// Scoreboard bench for alu_pipe_shared: directed opcode cases, back-pressure and reset.
module tb_alu_pipe_shared;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] input_a = '0, input_b = '0, input_c = '0, input_d = '0;
    logic [3:0] opcode = '0;
    logic       sel = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       zero_flag, carry_flag;

    alu_pipe_shared #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .input_a(input_a), .input_b(input_b), .input_c(input_c), .input_d(input_d),
        .opcode(opcode), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] acc_m = '0;
    int         n_cmp = 0, n_err = 0, cyc = 0, n_acc = 0;
    bit         prev_stall = 0;
    logic [9:0] prev_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: computes each op directly from the raw operands.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, b, c, d,
                                   input logic s);
        exp_t       e;
        logic [9:0] t;
        e.res = '0; e.c = 1'b0; e.cyc = 0; e.lat = 0;
        case (op)
            4'h0, 4'h7: begin
                t = 10'(a) + 10'(b) + 10'(c) + 10'(d);
                e.res = t[7:0]; e.c = (t >= 10'd256);
            end
            4'h1: begin e.res = a - b; e.c = (a < b); end
            4'h2: e.res = a & b;
            4'h3: e.res = a | b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = ~a;
            4'h6: begin
                t = s ? (10'(a) + 10'(c)) : (10'(b) + 10'(d));
                e.res = t[7:0]; e.c = t[8];
            end
            4'h8: begin
                t = 10'(acc_m) + 10'(a);
                e.res = t[7:0]; e.c = t[8]; acc_m = t[7:0];
            end
            4'h9: acc_m = '0;
            default: ;
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic step(input logic v, input logic [3:0] op, input logic [7:0] a, b, c, d,
                        input logic s, input logic ordy, input bit lat);
        exp_t e;
        in_valid = v; opcode = op; input_a = a; input_b = b; input_c = c; input_d = d;
        sel = s; out_ready = ordy;
        @(negedge clk);
        check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", {result, zero_flag, carry_flag}, prev_out);
        end
        if (out_valid && sb.size() == 0) check("spurious_out", out_valid, 0);
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("zero", zero_flag, e.z);
            check("carry", carry_flag, e.c);
            if (e.lat) check("latency", cyc - e.cyc, 2);
        end
        if (in_valid && in_ready) begin
            e = model(op, a, b, c, d, s);
            e.cyc = cyc; e.lat = lat;
            sb.push_back(e);
            n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {result, zero_flag, carry_flag};
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic op1(input logic [3:0] op, input logic [7:0] a, b, c, d, input logic s);
        step(1'b1, op, a, b, c, d, s, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero_flag, 0);
        check("rst_carry", carry_flag, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        op1(4'h0, 8'h40, 8'h40, 8'h40, 8'h41, 1'b0);
        op1(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        op1(4'h7, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        op1(4'h1, 8'h05, 8'h07, 8'h00, 8'h00, 1'b0);
        op1(4'h6, 8'h10, 8'h01, 8'h20, 8'h02, 1'b1);
        op1(4'h6, 8'h10, 8'h01, 8'h20, 8'h02, 1'b0);
        op1(4'h5, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        op1(4'h2, 8'hF0, 8'h3C, 8'h00, 8'h00, 1'b0);
        op1(4'h3, 8'hF0, 8'h0C, 8'h00, 8'h00, 1'b0);
        op1(4'h4, 8'hFF, 8'h0F, 8'h00, 8'h00, 1'b0);
        idle(3);

        op1(4'h9, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        op1(4'h8, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
        op1(4'h8, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
        op1(4'h8, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(3);

        for (int i = 0; i < 5000 && n_acc < 213; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 6), 1'b0);
        if (n_acc < 213) check("rand_budget", n_acc, 213);
        for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        check("drain_empty", sb.size(), 0);

        step(1'b1, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h8, 8'h07, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("stall_full", sb.size(), 2);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        acc_m = '0;
        prev_stall = 0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        op1(4'h8, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(3);

        op1(4'hC, 8'h5A, 8'hA5, 8'h33, 8'hCC, 1'b1);
        op1(4'h8, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(4);
        check("final_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
